// File: rtl/regfile_pkg.sv
// Shared constants, command field positions and FSM state encoding for the
// register-file host. Optional write-verify build: REGFILE_HOST_VERIFY_EN.
package regfile_pkg;

   localparam int WIDTH    = 4;
   localparam int ADDR_W   = 3;
   localparam int NUM_REGS = 8;

   // Packed 8-bit command layout
   localparam int OP_BIT     = 7;
   localparam int WADDR_HI   = 6;
   localparam int WADDR_LO   = 4;
   localparam int WDATA_HI   = 3;
   localparam int WDATA_LO   = 0;
   localparam int RADDRA_HI  = 6;
   localparam int RADDRA_LO  = 4;
   localparam int RADDRB_HI  = 2;
   localparam int RADDRB_LO  = 0;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      WRITE  = 3'd1,
      READ   = 3'd2,
      RESP   = 3'd3,
      VERIFY = 3'd4
   } state_t;

endpackage

// File: rtl/regfile_host.sv
// Command-driven initiator for an 8x4 register file: byte commands in, byte
// read responses out. Define REGFILE_HOST_VERIFY_EN for post-write read-back check.
module regfile_host #(
   parameter int WIDTH  = 4,
   parameter int ADDR_W = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [7:0]        cmd_data,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [7:0]        rsp_data,
   output logic [ADDR_W-1:0] rf_read_reg1,
   output logic [ADDR_W-1:0] rf_read_reg2,
   input  logic [WIDTH-1:0]  rf_read_data1,
   input  logic [WIDTH-1:0]  rf_read_data2,
   output logic [ADDR_W-1:0] rf_write_reg,
   output logic [WIDTH-1:0]  rf_write_data,
   output logic              rf_we,
   output logic              busy,
   output logic              verify_err
);
   import regfile_pkg::*;

   // The byte packing only works for 4-bit data and 3-bit addresses.
   generate
      if (WIDTH != 4) begin : g_bad_width
         $error("regfile_host: WIDTH must be 4");
      end
      if ((1 << ADDR_W) != NUM_REGS) begin : g_bad_addr
         $error("regfile_host: ADDR_W must address exactly NUM_REGS entries");
      end
   endgenerate

   state_t            state_reg, state_next;
   logic [ADDR_W-1:0] read_reg1_reg, read_reg2_reg, write_reg_reg;
   logic [WIDTH-1:0]  write_data_reg;
   logic [7:0]        rsp_data_reg;
   logic              accept;
   logic              is_write;

   assign accept   = cmd_valid && (state_reg == IDLE);
   assign is_write = cmd_data[OP_BIT];

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:   if (accept) state_next = is_write ? WRITE : READ;
`ifdef REGFILE_HOST_VERIFY_EN
         WRITE:  state_next = VERIFY;
         VERIFY: state_next = IDLE;
`else
         WRITE:  state_next = IDLE;
`endif
         READ:   state_next = RESP;
         RESP:   if (rsp_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg      <= IDLE;
         read_reg1_reg  <= '0;
         read_reg2_reg  <= '0;
         write_reg_reg  <= '0;
         write_data_reg <= '0;
         rsp_data_reg   <= '0;
      end else begin
         state_reg <= state_next;
         if (accept && is_write) begin
            write_reg_reg  <= cmd_data[WADDR_HI:WADDR_LO];
            write_data_reg <= cmd_data[WDATA_HI:WDATA_LO];
         end
         if (accept && !is_write) begin
            read_reg1_reg <= cmd_data[RADDRA_HI:RADDRA_LO];
            read_reg2_reg <= cmd_data[RADDRB_HI:RADDRB_LO];
         end
`ifdef REGFILE_HOST_VERIFY_EN
         // Point port 1 at the just-written entry for the read-back cycle.
         if (state_reg == WRITE)
            read_reg1_reg <= write_reg_reg;
`endif
         if (state_reg == READ)
            rsp_data_reg <= {rf_read_data2, rf_read_data1};
      end
   end

`ifdef REGFILE_HOST_VERIFY_EN
   logic             verify_err_reg;
   logic [WIDTH-1:0] verify_expect;

   // Entry 0 is hardwired to zero in the file, so that is what reads back.
   assign verify_expect = (write_reg_reg == '0) ? '0 : write_data_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         verify_err_reg <= 1'b0;
      else if ((state_reg == VERIFY) && (rf_read_data1 != verify_expect))
         verify_err_reg <= 1'b1;
   end

   assign verify_err = verify_err_reg;
`else
   assign verify_err = 1'b0;
`endif

   assign cmd_ready     = (state_reg == IDLE);
   assign busy          = (state_reg != IDLE);
   assign rsp_valid     = (state_reg == RESP);
   assign rsp_data      = rsp_data_reg;
   assign rf_we         = (state_reg == WRITE);
   assign rf_write_reg  = write_reg_reg;
   assign rf_write_data = write_data_reg;
   assign rf_read_reg1  = read_reg1_reg;
   assign rf_read_reg2  = read_reg2_reg;

endmodule

// File: tb/tb_regfile_host.sv
// Directed bench for regfile_host with a behavioural 8x4 register file
// (entry 0 reads zero, writes to it ignored) and a stuck-at-0 read port option.
module tb_regfile_host;

   logic       clk = 1'b0;
   logic       rst;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [7:0] cmd_data;
   logic       rsp_valid;
   logic       rsp_ready;
   logic [7:0] rsp_data;
   logic [2:0] rf_read_reg1, rf_read_reg2, rf_write_reg;
   logic [3:0] rf_read_data1, rf_read_data2, rf_write_data;
   logic       rf_we;
   logic       busy;
   logic       verify_err;
   logic       stuck;

   int total = 0;
   int bad   = 0;

   logic [3:0] mem [8] = '{default: 4'h0};

   always #5 clk = ~clk;

   always @(posedge clk)
      if (rf_we && (rf_write_reg != 3'd0))
         mem[rf_write_reg] <= rf_write_data;

   assign rf_read_data1 = (stuck || (rf_read_reg1 == 3'd0)) ? 4'h0 : mem[rf_read_reg1];
   assign rf_read_data2 = (rf_read_reg2 == 3'd0) ? 4'h0 : mem[rf_read_reg2];

   regfile_host dut (
      .clk           (clk),
      .rst           (rst),
      .cmd_valid     (cmd_valid),
      .cmd_ready     (cmd_ready),
      .cmd_data      (cmd_data),
      .rsp_valid     (rsp_valid),
      .rsp_ready     (rsp_ready),
      .rsp_data      (rsp_data),
      .rf_read_reg1  (rf_read_reg1),
      .rf_read_reg2  (rf_read_reg2),
      .rf_read_data1 (rf_read_data1),
      .rf_read_data2 (rf_read_data2),
      .rf_write_reg  (rf_write_reg),
      .rf_write_data (rf_write_data),
      .rf_we         (rf_we),
      .busy          (busy),
      .verify_err    (verify_err)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic do_write(input logic [7:0] c);
      cmd_valid = 1'b1;
      cmd_data  = c;
      step();
      cmd_valid = 1'b0;
      check("wr_we", 8'(rf_we), 8'h01);
      check("wr_addr", 8'(rf_write_reg), 8'(c[6:4]));
      check("wr_data", 8'(rf_write_data), 8'(c[3:0]));
      check("wr_rdy_busy", {6'd0, cmd_ready, busy}, 8'h01);
      step();
`ifdef REGFILE_HOST_VERIFY_EN
      check("vf_we_off", 8'(rf_we), 8'h00);
      check("vf_addr", 8'(rf_read_reg1), 8'(c[6:4]));
      check("vf_busy", 8'(busy), 8'h01);
      step();
`endif
      check("wr_we_off", 8'(rf_we), 8'h00);
      check("wr_hold", 8'(rf_write_reg), 8'(c[6:4]));
      check("wr_idle", 8'(cmd_ready), 8'h01);
      $display("write cmd=%h addr=%0d data=%h", c, c[6:4], c[3:0]);
   endtask

   task automatic do_read(input logic [7:0] c, input logic [7:0] exp);
      cmd_valid = 1'b1;
      cmd_data  = c;
      step();
      cmd_valid = 1'b0;
      check("rd_addr1", 8'(rf_read_reg1), 8'(c[6:4]));
      check("rd_addr2", 8'(rf_read_reg2), 8'(c[2:0]));
      check("rd_novalid", 8'(rsp_valid), 8'h00);
      step();
      check("rsp_valid", 8'(rsp_valid), 8'h01);
      check("rsp_data", rsp_data, exp);
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      check("rsp_done", {6'd0, rsp_valid, cmd_ready}, 8'h01);
      $display("read cmd=%h rsp=%h expected=%h", c, rsp_data, exp);
   endtask

   initial begin
      rst       = 1'b1;
      cmd_valid = 1'b0;
      cmd_data  = 8'h00;
      rsp_ready = 1'b0;
      stuck     = 1'b0;
      step();
      step();
      check("rst_ready", 8'(cmd_ready), 8'h01);
      check("rst_valid", 8'(rsp_valid), 8'h00);
      check("rst_data", rsp_data, 8'h00);
      check("rst_we", 8'(rf_we), 8'h00);
      check("rst_busy", 8'(busy), 8'h00);
      check("rst_verr", 8'(verify_err), 8'h00);
      check("rst_addrs", {2'd0, rf_read_reg1, rf_read_reg2}, 8'h00);
      check("rst_wport", {1'b0, rf_write_reg, rf_write_data}, 8'h00);
      rst = 1'b0;
      step();

      // Basic write then read of reg1/reg2
      do_write(8'h9A);
      do_read(8'h12, 8'h0A);

      // Read-after-write on the same entry
      do_write(8'hB5);
      do_read(8'h33, 8'h55);

      // Response backpressure with a competing command
      cmd_valid = 1'b1;
      cmd_data  = 8'h13;
      step();
      cmd_valid = 1'b0;
      step();
      cmd_valid = 1'b1;
      cmd_data  = 8'h80;
      for (int i = 0; i < 5; i++) begin
         check("stall_valid", 8'(rsp_valid), 8'h01);
         check("stall_data", rsp_data, 8'h5A);
         check("stall_ready", 8'(cmd_ready), 8'h00);
         check("stall_we", 8'(rf_we), 8'h00);
         step();
      end
      cmd_valid = 1'b0;
      rsp_ready = 1'b1;
      check("stall_last", rsp_data, 8'h5A);
      step();
      rsp_ready = 1'b0;
      check("stall_release", {5'd0, rsp_valid, cmd_ready, busy}, 8'h02);
      $display("stall rsp=5A held 5 cycles");

      // rsp_ready with no response pending
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      check("idle_rdy", {6'd0, rsp_valid, busy}, 8'h00);

      // Entry 0 ignores writes
      do_write(8'h8F);
      do_read(8'h00, 8'h00);
      check("reg0_verr", 8'(verify_err), 8'h00);

      // Reset during RESP
      cmd_valid = 1'b1;
      cmd_data  = 8'h33;
      step();
      cmd_valid = 1'b0;
      step();
      check("rr_pre_valid", 8'(rsp_valid), 8'h01);
      #2 rst = 1'b1;
      #1;
      check("rr_valid", 8'(rsp_valid), 8'h00);
      check("rr_ready", 8'(cmd_ready), 8'h01);
      check("rr_data", rsp_data, 8'h00);
      step();
      rst = 1'b0;
      step();
      check("rr_after", {6'd0, cmd_ready, rsp_valid}, 8'h02);
      $display("reset in RESP: response discarded");

      // Reset during WRITE aborts the commit
      cmd_valid = 1'b1;
      cmd_data  = 8'hC9;
      step();
      cmd_valid = 1'b0;
      check("rw_pre_we", 8'(rf_we), 8'h01);
      #2 rst = 1'b1;
      #1;
      check("rw_we", 8'(rf_we), 8'h00);
      check("rw_wreg", 8'(rf_write_reg), 8'h00);
      step();
      rst = 1'b0;
      step();
      check("rw_after", {6'd0, cmd_ready, rsp_valid}, 8'h02);
      do_read(8'h44, 8'h00);

`ifdef REGFILE_HOST_VERIFY_EN
      // Stuck read port makes the read-back disagree
      stuck = 1'b1;
      do_write(8'hB7);
      check("vf_err_set", 8'(verify_err), 8'h01);
      step();
      step();
      stuck = 1'b0;
      check("vf_err_sticky", 8'(verify_err), 8'h01);
      do_read(8'h33, 8'h77);
      check("vf_err_hold", 8'(verify_err), 8'h01);
      rst = 1'b1;
      step();
      rst = 1'b0;
      step();
      check("vf_err_clr", 8'(verify_err), 8'h00);
      $display("verify stuck-at-0: verify_err sticky until rst");
`else
      check("verr_tied", 8'(verify_err), 8'h00);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
